// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// The parity helper is only referenced when IMEM_PARITY_EN is defined.
package imem_pkg;

    localparam logic [31:0] NOP_WORD     = 32'h00000013;
    localparam int          PARITY_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } ld_state_t;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_loadable_if.sv
// Fetch and loader bus of the loadable instruction memory.
// master = IF stage / boot loader side, slave = memory side.
interface imem_loadable_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic              fetch_req;
    logic [PC_W-1:0]   fetch_pc;
    logic              fetch_stall;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fetch_fault;
    logic              busy;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic              ld_ovf;
    logic              parity_err;

    modport master (
        output fetch_req, fetch_pc, fetch_stall,
        output ld_start, ld_base, ld_valid, ld_data, ld_last,
        input  instr, instr_valid, fetch_fault, busy,
        input  ld_ready, ld_done, ld_ovf, parity_err
    );

    modport slave (
        input  fetch_req, fetch_pc, fetch_stall,
        input  ld_start, ld_base, ld_valid, ld_data, ld_last,
        output instr, instr_valid, fetch_fault, busy,
        output ld_ready, ld_done, ld_ovf, parity_err
    );
endinterface

// File: rtl/imem_array.sv
// DEPTH-word storage, one synchronous write port and one synchronous read port.
// With IMEM_PARITY_EN defined, a parity bit is stored alongside each word.
module imem_array #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`ifdef IMEM_PARITY_EN
    input  logic              wr_par,
    output logic              rd_par,
`endif
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read data register only moves on an enabled read, so it holds the last fetch.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) par_mem[wr_addr] <= wr_par;
        if (rd_en) rd_par <= par_mem[rd_addr];
    end
`endif

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with a registered 1-cycle fetch port and a streaming loader.
// Optional stored-parity checking is enabled with IMEM_PARITY_EN.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 32,
    parameter int                PC_W     = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = imem_pkg::NOP_WORD
) (
    input logic            clk,
    input logic            rst_n,
    imem_loadable_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    ld_state_t         state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic              wr_en, ovf_next, ovf_q;
    logic              fetch_accept, addr_fault, rd_en;
    logic              valid_q, fault_q, use_ram_q;
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            ovf_q <= ovf_next;
        end
    end

    // A session ends on ld_last or after writing the top word; the pointer never wraps.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        wr_en      = 1'b0;
        ovf_next   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ld_start) begin
                    state_next = LOAD;
                    ptr_next   = bus.ld_base;
                end
            end
            LOAD: begin
                if (bus.ld_valid) begin
                    wr_en    = 1'b1;
                    ptr_next = ptr + ADDR_W'(1);
                    if (bus.ld_last) begin
                        state_next = FINISH;
                    end else if (ptr == LAST_ADDR) begin
                        state_next = FINISH;
                        ovf_next   = 1'b1;
                    end
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy     = (state == LOAD);
    assign bus.ld_ready = (state == LOAD);
    assign bus.ld_done  = (state == FINISH);
    assign bus.ld_ovf   = ovf_q;

    assign fetch_accept = bus.fetch_req && !bus.fetch_stall && !bus.busy;
    assign addr_fault   = (bus.fetch_pc[1:0] != 2'b00) ||
                          (bus.fetch_pc[PC_W-1:ADDR_W+2] != '0);
    assign rd_en        = fetch_accept && !addr_fault;

    // use_ram_q selects the array word or NOP; it only changes on an accepted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            use_ram_q <= 1'b0;
        end else if (!bus.fetch_stall) begin
            valid_q <= fetch_accept;
            fault_q <= fetch_accept && addr_fault;
            if (fetch_accept) use_ram_q <= !addr_fault;
        end
    end

    assign bus.instr       = use_ram_q ? rd_data : NOP_WORD;
    assign bus.instr_valid = valid_q;
    assign bus.fetch_fault = fault_q;

`ifdef IMEM_PARITY_EN
    logic wr_par, rd_par;

    assign wr_par         = even_parity(PARITY_MAX_W'(bus.ld_data));
    assign bus.parity_err = valid_q && use_ram_q &&
                            (even_parity(PARITY_MAX_W'(rd_data)) != rd_par);
`else
    assign bus.parity_err = 1'b0;
`endif

    imem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ptr),
        .wr_data (bus.ld_data),
`ifdef IMEM_PARITY_EN
        .wr_par  (wr_par),
        .rd_par  (rd_par),
`endif
        .rd_en   (rd_en),
        .rd_addr (bus.fetch_pc[ADDR_W+1:2]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: fetch expectations are queued by the stimulus
// and popped by a monitor whenever instr_valid is seen; loader signals checked directly.
module tb_imem_loadable;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        logic        perr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] ld_words [4];

    imem_loadable_if #(.ADDR_W(6), .DATA_W(32), .PC_W(32)) bus ();

    imem_loadable #(
        .ADDR_W   (6),
        .DATA_W   (32),
        .PC_W     (32),
        .NOP_WORD (32'h00000013)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] pc, input logic [31:0] exp_instr,
                                  input logic exp_fault, input logic exp_perr);
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = pc;
        exp_q.push_back('{exp_instr, exp_fault, exp_perr});
        @(posedge clk); #1;
        bus.fetch_req = 1'b0;
    endtask

    // Returns during the FINISH cycle, with the loader checks for that cycle done.
    task automatic load_session(input logic [5:0] base, input int n, input bit use_last,
                                input int exp_writes, input bit exp_ovf, input bit fetch_busy);
        bus.ld_start = 1'b1;
        bus.ld_base  = base;
        @(posedge clk); #1;
        bus.ld_start = 1'b0;
        check_output("busy_in_load", 32'(bus.busy), 32'd1);
        check_output("ready_in_load", 32'(bus.ld_ready), 32'd1);
        for (int i = 0; i < exp_writes; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = ld_words[i];
            bus.ld_last  = use_last && (i == n - 1);
            if (fetch_busy && i == 0) begin
                bus.fetch_req = 1'b1;
                bus.fetch_pc  = 32'h0;
            end
            @(posedge clk); #1;
            bus.fetch_req = 1'b0;
            if (fetch_busy && i == 0)
                check_output("fetch_refused_busy", 32'(bus.instr_valid), 32'd0);
        end
        check_output("ld_done_pulse", 32'(bus.ld_done), 32'd1);
        check_output("ld_ovf_flag", 32'(bus.ld_ovf), 32'(exp_ovf));
        check_output("busy_in_finish", 32'(bus.busy), 32'd0);
        check_output("ready_in_finish", 32'(bus.ld_ready), 32'd0);
        bus.ld_last = 1'b0;
        if (exp_writes < n) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = ld_words[exp_writes];
        end else begin
            bus.ld_valid = 1'b0;
        end
    endtask

    // Monitor: every cycle with instr_valid consumes exactly one queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.instr_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_valid: got instr=%h fault=%b with nothing expected",
                         bus.instr, bus.fetch_fault);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.instr, bus.fetch_fault, bus.parity_err} !== {mon_e.instr, mon_e.fault, mon_e.perr}) begin
                    bad++;
                    $display("[TB] FAIL fetch_result: got instr=%h fault=%b perr=%b expected instr=%h fault=%b perr=%b",
                             bus.instr, bus.fetch_fault, bus.parity_err, mon_e.instr, mon_e.fault, mon_e.perr);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.fetch_req   = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_stall = 1'b0;
        bus.ld_start    = 1'b0;
        bus.ld_base     = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_data     = '0;
        bus.ld_last     = 1'b0;

        #12;
        check_output("rst_instr", bus.instr, 32'h00000013);
        check_output("rst_valid", 32'(bus.instr_valid), 32'd0);
        check_output("rst_busy", 32'(bus.busy), 32'd0);
        check_output("rst_ready", 32'(bus.ld_ready), 32'd0);
        check_output("rst_done", 32'(bus.ld_done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] load three words at base 0, then fetch them");
        ld_words[0] = 32'h00500093;
        ld_words[1] = 32'h00A00113;
        ld_words[2] = 32'h002081B3;
        load_session(6'd0, 3, 1'b1, 3, 1'b0, 1'b0);
        apply_stimulus(32'h8, 32'h002081B3, 1'b0, 1'b0);
        check_output("done_cleared", 32'(bus.ld_done), 32'd0);
        apply_stimulus(32'h0, 32'h00500093, 1'b0, 1'b0);
        apply_stimulus(32'h4, 32'h00A00113, 1'b0, 1'b0);

        $display("[TB] misaligned and out-of-range fetches");
        apply_stimulus(32'h6, 32'h00000013, 1'b1, 1'b0);
        apply_stimulus(32'h100, 32'h00000013, 1'b1, 1'b0);
        apply_stimulus(32'h8, 32'h002081B3, 1'b0, 1'b0);

        $display("[TB] stall holds the fetched word");
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 32'h4;
        exp_q.push_back('{32'h00A00113, 1'b0, 1'b0});
        @(posedge clk); #1;
        bus.fetch_stall = 1'b1;
        bus.fetch_pc    = 32'h8;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{32'h00A00113, 1'b0, 1'b0});
            @(posedge clk); #1;
        end
        bus.fetch_stall = 1'b0;
        exp_q.push_back('{32'h002081B3, 1'b0, 1'b0});
        @(posedge clk); #1;
        bus.fetch_req = 1'b0;
        @(posedge clk); #1;
        check_output("idle_valid_low", 32'(bus.instr_valid), 32'd0);
        check_output("idle_instr_held", bus.instr, 32'h002081B3);

        $display("[TB] load running off the end of the array");
        ld_words[0] = 32'hDEAD0001;
        ld_words[1] = 32'hDEAD0002;
        ld_words[2] = 32'hDEAD0003;
        load_session(6'd62, 3, 1'b0, 2, 1'b1, 1'b1);
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        check_output("ovf_cleared", 32'(bus.ld_ovf), 32'd0);
        check_output("done_cleared_ovf", 32'(bus.ld_done), 32'd0);
        check_output("busy_after_ovf", 32'(bus.busy), 32'd0);
        apply_stimulus(32'hFC, 32'hDEAD0002, 1'b0, 1'b0);
        apply_stimulus(32'hF8, 32'hDEAD0001, 1'b0, 1'b0);
        apply_stimulus(32'h0, 32'h00500093, 1'b0, 1'b0);

        $display("[TB] reset in the middle of a load");
        bus.ld_start = 1'b1;
        bus.ld_base  = 6'd10;
        @(posedge clk); #1;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'h11110001;
        @(posedge clk); #1;
        bus.ld_data  = 32'h11110002;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_instr", bus.instr, 32'h00000013);
        check_output("midrst_valid", 32'(bus.instr_valid), 32'd0);
        check_output("midrst_fault", 32'(bus.fetch_fault), 32'd0);
        check_output("midrst_busy", 32'(bus.busy), 32'd0);
        check_output("midrst_ready", 32'(bus.ld_ready), 32'd0);
        check_output("midrst_done", 32'(bus.ld_done), 32'd0);
        check_output("midrst_ovf", 32'(bus.ld_ovf), 32'd0);
        check_output("midrst_perr", 32'(bus.parity_err), 32'd0);
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("postrst_busy", 32'(bus.busy), 32'd0);
        check_output("postrst_done", 32'(bus.ld_done), 32'd0);
        apply_stimulus(32'h28, 32'h11110001, 1'b0, 1'b0);

`ifdef IMEM_PARITY_EN
        $display("[TB] corrupted parity bit on word 1");
        dut.u_array.par_mem[1] = 1'b1;
        apply_stimulus(32'h4, 32'h00A00113, 1'b0, 1'b1);
        apply_stimulus(32'h0, 32'h00500093, 1'b0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL missing_fetches: %0d expected results never appeared, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
